// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear sequencer for a four-digit BCD stopwatch.
// A prescaler turns the fast clock into a count-enable tick. Four cascaded
// decade digits ripple their carry combinationally so every digit updates on
// the same edge. A lap register snapshots the count on request.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] q,
  output logic        running,
  output logic [15:0] lap_q,
  output logic        lap_valid,
  output logic        ovf
);

  // Prescaler width; a divide-by-one still needs a one-bit register.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  // Sequencer states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // Decade increment. Any value at or above 9 wraps to 0, so a digit that
  // somehow held a non-BCD code is pulled back into range on its next carry.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd9) begin
      r = 4'd0;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

  // Registers.
  logic [1:0]    state_q,     state_d;
  logic [PW-1:0] pre_q,       pre_d;
  logic [15:0]   cnt_q,       cnt_d;
  logic          ovf_q,       ovf_d;
  logic [15:0]   lap_cap_q,   lap_cap_d;
  logic          lap_valid_q, lap_valid_d;
  logic          running_q,   running_d;

  // Combinational helpers.
  logic       tick_s;
  logic [3:0] nine_s;
  logic [3:0] inc_en_s;
  logic       all_nine_s;
  logic       clear_hon_s;
  logic       lap_hon_s;

  // Tick, per-digit nine detect and the ripple-carry enables.
  always_comb begin
    tick_s      = (state_q == ST_RUN) && (pre_q == PRE_LAST);
    nine_s[0]   = (cnt_q[3:0]   == 4'd9);
    nine_s[1]   = (cnt_q[7:4]   == 4'd9);
    nine_s[2]   = (cnt_q[11:8]  == 4'd9);
    nine_s[3]   = (cnt_q[15:12] == 4'd9);
    all_nine_s  = &nine_s;
    inc_en_s[0] = tick_s;
    inc_en_s[1] = tick_s && nine_s[0];
    inc_en_s[2] = tick_s && nine_s[0] && nine_s[1];
    inc_en_s[3] = tick_s && nine_s[0] && nine_s[1] && nine_s[2];
    clear_hon_s = clear && (state_q != ST_RUN);
    lap_hon_s   = lap && (state_q == ST_RUN);
  end

  // Next state. A higher-priority command blocks lower ones even when it
  // has no effect itself (start+stop in IDLE stays in IDLE).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d = ST_RUN;
        end else if (stop) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else if (stop) begin
          state_d = ST_PAUSE;
        end else if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Prescaler: advances in RUN, holds its fraction in PAUSE, zero in IDLE.
  always_comb begin
    pre_d = pre_q;
    case (state_q)
      ST_RUN: begin
        if (pre_q >= PRE_LAST) begin
          pre_d = PRE_ZERO;
        end else begin
          pre_d = pre_q + PRE_ONE;
        end
      end
      ST_PAUSE: begin
        if (clear_hon_s) begin
          pre_d = PRE_ZERO;
        end else begin
          pre_d = pre_q;
        end
      end
      ST_IDLE: begin
        pre_d = PRE_ZERO;
      end
      default: begin
        pre_d = PRE_ZERO;
      end
    endcase
  end

  // Decade digits and the sticky overflow flag.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_hon_s) begin
      cnt_d = 16'h0000;
      ovf_d = 1'b0;
    end else begin
      cnt_d[3:0]   = inc_en_s[0] ? bcd_inc(cnt_q[3:0])   : cnt_q[3:0];
      cnt_d[7:4]   = inc_en_s[1] ? bcd_inc(cnt_q[7:4])   : cnt_q[7:4];
      cnt_d[11:8]  = inc_en_s[2] ? bcd_inc(cnt_q[11:8])  : cnt_q[11:8];
      cnt_d[15:12] = inc_en_s[3] ? bcd_inc(cnt_q[15:12]) : cnt_q[15:12];
      if (tick_s && all_nine_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // Lap capture of the pre-increment count, and the registered run flag.
  always_comb begin
    lap_cap_d   = lap_cap_q;
    lap_valid_d = 1'b0;
    if (lap_hon_s) begin
      lap_cap_d   = cnt_q;
      lap_valid_d = 1'b1;
    end else begin
      lap_cap_d   = lap_cap_q;
      lap_valid_d = 1'b0;
    end
    running_d = (state_d == ST_RUN);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pre_q       <= PRE_ZERO;
      cnt_q       <= 16'h0000;
      ovf_q       <= 1'b0;
      lap_cap_q   <= 16'h0000;
      lap_valid_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      lap_cap_q   <= lap_cap_d;
      lap_valid_q <= lap_valid_d;
      running_q   <= running_d;
    end
  end

  assign q         = cnt_q;
  assign running   = running_q;
  assign lap_q     = lap_cap_q;
  assign lap_valid = lap_valid_q;
  assign ovf       = ovf_q;

endmodule
